// File: rtl/alu_share_pkg.sv
// Shared op-code and sequencer state definitions for the shared ALU arbiter.
package alu_share_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_ADD2 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational DW-bit ALU producing a DW+1-bit result from zero-extended operands.
module alu_core
  import alu_share_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [1:0]    code,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW:0]   y
);

  logic [DW:0] ax;
  logic [DW:0] bx;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  always_comb begin
    y = '0;
    case (code)
      OP_ADD:  y = ax + bx;
      OP_OR:   y = ax | bx;
      OP_SUB:  y = ax - bx;
      OP_ADD2: y = ax + bx;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters; grant, compute, respond.
//   state | meaning
//   IDLE  | waiting for a request; winner's operands latched on leaving
//   EXEC  | grant pulse to winner; ALU result registered into res
//   RESP  | valid strobe to winner; res stable
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    code0,
  input  logic [1:0]    code1,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          vld0,
  output logic          vld1,
  output logic [DW:0]   res,
  output logic          busy
);

  state_t        state;
  state_t        state_nx;
  logic          win;
  logic          last;
  logic          pick1;
  logic [1:0]    code_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW:0]   alu_y;

  // requester 1 wins when alone, or on a tie when requester 0 was served last
  assign pick1 = req1 & (~req0 | ~last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win    <= 1'b0;
      last   <= 1'b1;
      code_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res    <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        win    <= pick1;
        code_q <= pick1 ? code1 : code0;
        a_q    <= pick1 ? a1 : a0;
        b_q    <= pick1 ? b1 : b0;
      end
      if (state == EXEC) begin
        res  <= alu_y;
        last <= win;
      end
    end
  end

  alu_core #(.DW(DW)) u_alu (
    .code (code_q),
    .a    (a_q),
    .b    (b_q),
    .y    (alu_y)
  );

  assign gnt0 = (state == EXEC) && !win;
  assign gnt1 = (state == EXEC) &&  win;
  assign vld0 = (state == RESP) && !win;
  assign vld1 = (state == RESP) &&  win;
  assign busy = (state == EXEC) || (state == RESP);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and random transactions against a round-robin / arithmetic reference model.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [1:0] code0, code1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, vld0, vld1, busy;
  logic [4:0] res;

  int n_pass   = 0;
  int n_total  = 0;
  int cyc      = 0;
  int last_srv = 1;

  alu_share_arbiter #(.DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .code0 (code0),
    .code1 (code1),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .vld0  (vld0),
    .vld1  (vld1),
    .res   (res),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int ref_alu(input int c, input int a, input int b);
    case (c)
      1:       return a | b;
      2:       return (a - b + 32) % 32;
      default: return a + b;
    endcase
  endfunction

  // Called at a falling edge while the sequencer is idle; returns the grant cycle.
  task automatic op(input bit r0, input bit r1, input logic [1:0] c0_i, input logic [1:0] c1_i,
                    input logic [3:0] pa0, input logic [3:0] pb0,
                    input logic [3:0] pa1, input logic [3:0] pb1,
                    input bit abort, output int gcyc);
    int w;
    int expv;
    req0 = r0; req1 = r1;
    code0 = c0_i; code1 = c1_i;
    a0 = pa0; b0 = pb0; a1 = pa1; b1 = pb1;
    if (r0 && r1) w = 1 - last_srv;
    else          w = r1 ? 1 : 0;
    expv = (w == 1) ? ref_alu(int'(c1_i), int'(pa1), int'(pb1))
                    : ref_alu(int'(c0_i), int'(pa0), int'(pb0));
    @(posedge clk); @(negedge clk);
    chk("gnt0_exec", gnt0, w == 0);
    chk("gnt1_exec", gnt1, w == 1);
    chk("vld_exec", {vld0, vld1}, 0);
    chk("busy_exec", busy, 1);
    gcyc = cyc;
    if (w == 0) req0 = 1'b0; else req1 = 1'b0;
    code0 = 2'($urandom); code1 = 2'($urandom);
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    last_srv = w;
    @(posedge clk); @(negedge clk);
    chk("vld0_resp", vld0, w == 0);
    chk("vld1_resp", vld1, w == 1);
    chk("gnt_resp", {gnt0, gnt1}, 0);
    chk("res_resp", res, expv);
    chk("busy_resp", busy, 1);
    if (abort) begin
      rst_n = 1'b0;
      #1;
      chk("vld_abort", {vld0, vld1}, 0);
      chk("gnt_abort", {gnt0, gnt1}, 0);
      chk("res_abort", res, 0);
      chk("busy_abort", busy, 0);
      last_srv = 1;
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      @(posedge clk); @(negedge clk);
      chk("busy_idle", busy, 0);
      chk("strobes_idle", {gnt0, gnt1, vld0, vld1}, 0);
      chk("res_hold", res, expv);
    end
  endtask

  initial begin
    int g, g_prev;
    bit r0, r1;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; code0 = 0; code1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {gnt0, gnt1, vld0, vld1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // contention straight out of reset alternates 0,1,0,1
    op(1, 1, 2'b00, 2'b11, 4'd1, 4'd2, 4'd7, 4'd7, 0, g);
    op(1, 1, 2'b01, 2'b10, 4'd5, 4'd10, 4'd2, 4'd9, 0, g);
    op(1, 1, 2'b10, 2'b00, 4'd0, 4'd1, 4'd15, 4'd15, 0, g);
    op(1, 1, 2'b11, 2'b01, 4'd15, 4'd15, 4'd12, 4'd3, 0, g);

    op(1, 0, 2'b00, 2'b00, 4'd9, 4'd8, 4'd0, 4'd0, 0, g);
    chk("add_9_8", res, 17);
    op(0, 1, 2'b00, 2'b01, 4'd0, 4'd0, 4'd3, 4'd5, 0, g);
    chk("or_3_5", res, 7);
    op(0, 1, 2'b00, 2'b10, 4'd0, 4'd0, 4'd3, 4'd5, 0, g);
    chk("sub_3_5", res, 30);
    op(0, 1, 2'b00, 2'b11, 4'd0, 4'd0, 4'd3, 4'd5, 0, g);
    chk("add2_3_5", res, 8);

    // operands scrambled in the grant cycle must not affect the result
    op(0, 1, 2'b00, 2'b00, 4'd0, 4'd0, 4'd15, 4'd1, 0, g);
    chk("latched_15_1", res, 16);

    op(1, 0, 2'b00, 2'b00, 4'd4, 4'd4, 4'd0, 4'd0, 0, g_prev);
    op(1, 0, 2'b10, 2'b00, 4'd4, 4'd6, 4'd0, 4'd0, 0, g);
    chk("b2b_spacing", g - g_prev, 3);

    op(1, 0, 2'b00, 2'b00, 4'd6, 4'd6, 4'd0, 4'd0, 1, g);
    op(1, 1, 2'b01, 2'b00, 4'd8, 4'd1, 4'd2, 4'd2, 0, g);
    chk("post_rst_winner", last_srv, 0);

    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      op(r0, r1, 2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
         4'($urandom), 4'($urandom), 0, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
